mem_wb_skid_stage: RTL and testbench

Parametrised MEM→WB pipeline boundary for the multi-issue core. It carries LANES parallel instruction slots from the memory stage into write-back. A valid/ready handshake with a one-entry skid buffer replaces the bare stall input, so the MEM stage sees a registered ready and loses no beat. On capture it applies in-order exception kill across lanes. Flush is handled in the same stage and the exception-flush marker is preserved.

---
 rtl/mem_wb_skid_stage_pkg.sv | 31 +++
 rtl/mem_wb_skid_stage_lane_kill.sv | 25 ++
 rtl/mem_wb_skid_stage.sv | 127 ++++++++++++
 tb/tb_mem_wb_skid_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_skid_stage_pkg.sv
// Shared MEM/WB core definitions: default field widths, the per-lane write-back
// record and the in-order exception kill helper.
package mem_wb_skid_stage_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_RA_W   = 5;
    localparam int MAX_LANES = 4;

    typedef struct packed {
        logic [WB_DATA_W-1:0] pc;
        logic [WB_DATA_W-1:0] aluout;
        logic [WB_RA_W-1:0]   writereg;
        logic                 regwrite;
        logic [WB_DATA_W-1:0] mem_rdata;
        logic [WB_DATA_W-1:0] result;
    } wb_lane_t;

    // Keep bit k is set when no lane below k raised an exception.
    function automatic logic [MAX_LANES-1:0] exc_keep_mask(input logic [MAX_LANES-1:0] exc);
        logic [MAX_LANES-1:0] keep;
        logic                 seen;
        keep = {MAX_LANES{1'b0}};
        seen = 1'b0;
        for (int k = 0; k < MAX_LANES; k++) begin
            keep[k] = ~seen;
            seen    = seen | exc[k];
        end
        return keep;
    endfunction

endpackage

// File: rtl/mem_wb_skid_stage_lane_kill.sv
// Clears regwrite of every lane younger than the oldest excepting lane.
module wb_lane_kill
    import mem_wb_skid_stage_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic [LANES-1:0] in_exc,
    input  logic [LANES-1:0] in_regwrite,
    output logic [LANES-1:0] out_regwrite
);

    logic [MAX_LANES-1:0] exc_pad_s;
    logic [MAX_LANES-1:0] keep_s;
    logic                 unused_keep_s;

    always_comb begin
        exc_pad_s              = {MAX_LANES{1'b0}};
        exc_pad_s[LANES-1:0]   = in_exc;
        keep_s                 = exc_keep_mask(exc_pad_s);
        out_regwrite           = in_regwrite & keep_s[LANES-1:0];
    end

    assign unused_keep_s = ^keep_s;

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB boundary: valid/ready handshake with a main register driving WB and a
// one-entry skid register so the registered in_ready never loses a beat.
module mem_wb_skid_stage
    import mem_wb_skid_stage_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int DATA_W = WB_DATA_W,
    parameter int RA_W   = WB_RA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_pc,
    input  logic [LANES*DATA_W-1:0] in_aluout,
    input  logic [LANES*DATA_W-1:0] in_mem_rdata,
    input  logic [LANES*DATA_W-1:0] in_result,
    input  logic [LANES*RA_W-1:0]   in_writereg,
    input  logic [LANES-1:0]        in_regwrite,
    input  logic [LANES-1:0]        in_exc,
    input  logic                    in_flush_exc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_pc,
    output logic [LANES*DATA_W-1:0] out_aluout,
    output logic [LANES*DATA_W-1:0] out_mem_rdata,
    output logic [LANES*DATA_W-1:0] out_result,
    output logic [LANES*RA_W-1:0]   out_writereg,
    output logic [LANES-1:0]        out_regwrite,
    output logic                    out_flush_exc
);

    // Flat beat layout, LSB first: regwrite, writereg, result, mem_rdata, aluout, pc.
    localparam int DW     = LANES * DATA_W;
    localparam int O_WR   = LANES;
    localparam int O_RES  = O_WR + LANES * RA_W;
    localparam int O_RD   = O_RES + DW;
    localparam int O_ALU  = O_RD + DW;
    localparam int O_PC   = O_ALU + DW;
    localparam int BEAT_W = O_PC + DW;

    logic [LANES-1:0]  killed_rw_s;
    logic [BEAT_W-1:0] in_beat_s;
    logic              accept_s;
    logic              pop_s;

    logic              m_valid_q, m_valid_d;
    logic              s_valid_q, s_valid_d;
    logic [BEAT_W-1:0] m_beat_q, m_beat_d;
    logic [BEAT_W-1:0] s_beat_q, s_beat_d;
    logic              flush_exc_q, flush_exc_d;

    wb_lane_kill #(.LANES(LANES)) u_lane_kill (
        .in_exc       (in_exc),
        .in_regwrite  (in_regwrite),
        .out_regwrite (killed_rw_s)
    );

    assign in_beat_s = {in_pc, in_aluout, in_mem_rdata, in_result, in_writereg, killed_rw_s};
    assign accept_s  = in_valid & ~s_valid_q;
    assign pop_s     = m_valid_q & out_ready;

    // Next-state for main/skid registers; emptied main slot has its regwrite cleared.
    always_comb begin
        m_valid_d   = m_valid_q;
        s_valid_d   = s_valid_q;
        m_beat_d    = m_beat_q;
        s_beat_d    = s_beat_q;
        flush_exc_d = flush_exc_q;
        if (flush) begin
            m_valid_d   = 1'b0;
            s_valid_d   = 1'b0;
            m_beat_d    = {BEAT_W{1'b0}};
            s_beat_d    = {BEAT_W{1'b0}};
            flush_exc_d = in_flush_exc;
        end else if (!m_valid_q || pop_s) begin
            if (s_valid_q) begin
                m_beat_d    = s_beat_q;
                m_valid_d   = 1'b1;
                s_valid_d   = 1'b0;
                s_beat_d    = {BEAT_W{1'b0}};
                flush_exc_d = in_flush_exc;
            end else if (accept_s) begin
                m_beat_d    = in_beat_s;
                m_valid_d   = 1'b1;
                flush_exc_d = in_flush_exc;
            end else begin
                m_valid_d            = 1'b0;
                m_beat_d[LANES-1:0]  = {LANES{1'b0}};
            end
        end else if (accept_s) begin
            s_beat_d  = in_beat_s;
            s_valid_d = 1'b1;
        end else begin
            s_valid_d = s_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q   <= 1'b0;
            s_valid_q   <= 1'b0;
            m_beat_q    <= {BEAT_W{1'b0}};
            s_beat_q    <= {BEAT_W{1'b0}};
            flush_exc_q <= 1'b0;
        end else begin
            m_valid_q   <= m_valid_d;
            s_valid_q   <= s_valid_d;
            m_beat_q    <= m_beat_d;
            s_beat_q    <= s_beat_d;
            flush_exc_q <= flush_exc_d;
        end
    end

    assign in_ready      = ~s_valid_q;
    assign out_valid     = m_valid_q;
    assign out_regwrite  = m_beat_q[LANES-1:0];
    assign out_writereg  = m_beat_q[O_WR +: LANES*RA_W];
    assign out_result    = m_beat_q[O_RES +: DW];
    assign out_mem_rdata = m_beat_q[O_RD +: DW];
    assign out_aluout    = m_beat_q[O_ALU +: DW];
    assign out_pc        = m_beat_q[O_PC +: DW];
    assign out_flush_exc = flush_exc_q;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Scoreboard bench for mem_wb_skid_stage with LANES=2.
module tb_mem_wb_skid_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_flush_exc;
    logic [63:0] in_pc, in_aluout, in_mem_rdata, in_result;
    logic [9:0]  in_writereg;
    logic [1:0]  in_regwrite, in_exc;
    logic        out_valid, out_ready, out_flush_exc;
    logic [63:0] out_pc, out_aluout, out_mem_rdata, out_result;
    logic [9:0]  out_writereg;
    logic [1:0]  out_regwrite;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] alu;
        logic [63:0] rdata;
        logic [63:0] res;
        logic [9:0]  wr;
        logic [1:0]  rw;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   idx;

    always #5 clk = ~clk;

    mem_wb_skid_stage #(.LANES(2), .DATA_W(32), .RA_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_aluout(in_aluout), .in_mem_rdata(in_mem_rdata),
        .in_result(in_result), .in_writereg(in_writereg), .in_regwrite(in_regwrite),
        .in_exc(in_exc), .in_flush_exc(in_flush_exc), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_aluout(out_aluout),
        .out_mem_rdata(out_mem_rdata), .out_result(out_result),
        .out_writereg(out_writereg), .out_regwrite(out_regwrite),
        .out_flush_exc(out_flush_exc)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Lane 0 excepting kills lane 1; lane 1 excepting kills nothing younger.
    function automatic logic [1:0] model_kill(input logic [1:0] exc, input logic [1:0] rw);
        if (exc[0]) return {1'b0, rw[0]};
        return rw;
    endfunction

    task automatic set_beat(input int i, input logic [1:0] exc, input logic [1:0] rw);
        in_pc        = {32'(32'h104 + 32'(8*i)), 32'(32'h100 + 32'(8*i))};
        in_aluout    = {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)};
        in_mem_rdata = {32'hC0DE_0000 + 32'(i), 32'hD00D_0000 + 32'(i)};
        in_result    = {32'(i * 3), 32'(i * 5 + 1)};
        in_writereg  = {5'(i + 1), 5'(i)};
        in_exc       = exc;
        in_regwrite  = rw;
    endtask

    // One cycle: compare a popped beat, record an accepted one, then advance.
    task automatic tick(output logic acc);
        exp_t e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check_eq("pc", out_pc, e.pc);
                check_eq("aluout", out_aluout, e.alu);
                check_eq("mem_rdata", out_mem_rdata, e.rdata);
                check_eq("result", out_result, e.res);
                check_eq("writereg", 64'(out_writereg), 64'(e.wr));
                check_eq("regwrite", 64'(out_regwrite), 64'(e.rw));
            end
        end
        acc = in_valid && in_ready;
        if (acc) begin
            e.pc = in_pc; e.alu = in_aluout; e.rdata = in_mem_rdata;
            e.res = in_result; e.wr = in_writereg;
            e.rw = model_kill(in_exc, in_regwrite);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int n, input int base, input int stall_start, input int stall_len);
        logic acc;
        int   c;
        idx = 0;
        c = 0;
        while ((idx < n || sb.size() != 0 || out_valid) && c < 200) begin
            out_ready = !(c >= stall_start && c < stall_start + stall_len);
            in_valid  = (idx < n);
            set_beat(base + idx, 2'(idx % 4), 2'(3 - (idx % 3)));
            if (stall_len == 0) check_eq("in_ready_held", 64'(in_ready), 64'd1);
            if (stall_len != 0 && c == stall_start + 1)
                check_eq("in_ready_backpressure", 64'(in_ready), 64'd0);
            tick(acc);
            if (acc && stall_len == 0) begin
                check_eq("latency_valid", 64'(out_valid), 64'd1);
                check_eq("latency_pc", out_pc, in_pc);
            end
            if (acc) idx++;
            c++;
        end
        in_valid = 1'b0;
        check_eq("stream_sent", 64'(idx), 64'(n));
        check_eq("stream_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_empty(input string tag, input logic fexc);
        check_eq({tag, "_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check_eq({tag, "_pc"}, out_pc, 64'd0);
        check_eq({tag, "_result"}, out_result, 64'd0);
        check_eq({tag, "_regwrite"}, 64'(out_regwrite), 64'd0);
        check_eq({tag, "_flush_exc"}, 64'(out_flush_exc), 64'(fexc));
    endtask

    task automatic fill_both();
        logic acc;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_beat(40, 2'b00, 2'b11);
        tick(acc);
        set_beat(41, 2'b00, 2'b11);
        tick(acc);
        check_eq("fill_in_ready", 64'(in_ready), 64'd0);
    endtask

    initial begin
        logic acc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_flush_exc = 1'b0; out_ready = 1'b1;
        set_beat(0, 2'b00, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_empty("reset", 1'b0);

        run_stream(4, 0, 1000, 0);
        run_stream(6, 8, 2, 3);

        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_beat(20, 2'b01, 2'b11);
        tick(acc);
        check_eq("kill_lane0", 64'(out_regwrite), 64'd1);
        set_beat(21, 2'b10, 2'b11);
        tick(acc);
        check_eq("kill_lane1", 64'(out_regwrite), 64'd3);
        in_valid = 1'b0;
        tick(acc);
        check_eq("kill_drained", 64'(sb.size()), 64'd0);

        fill_both();
        flush = 1'b1; in_valid = 1'b1; in_flush_exc = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0; in_flush_exc = 1'b0;
        sb.delete();
        check_empty("flush", 1'b1);

        out_ready = 1'b1; in_valid = 1'b1;
        set_beat(30, 2'b00, 2'b10);
        tick(acc);
        check_eq("fexc_reload", 64'(out_flush_exc), 64'd0);
        in_valid = 1'b0;
        tick(acc);

        fill_both();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        sb.delete();
        check_empty("rst_mid", 1'b0);

        flush = 1'b1; in_flush_exc = 1'b1;
        @(posedge clk);
        #1;
        check_eq("fexc_set", 64'(out_flush_exc), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0; in_flush_exc = 1'b0;
        check_eq("rst_over_flush", 64'(out_flush_exc), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
